// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared constants and codeword helpers for the shortened Hamming(15,11) code
//
// Shared by the encoder and decoder so both sides agree on the codeword layout.
//   DATA_W / CODE_W / PAR_W : data, codeword and parity widths
//   Px_IDX                  : codeword bit index of each parity bit (Hamming position - 1)
//   DATA_IDX[j]             : codeword bit index carrying data bit d[j]
//   assemble_code()         : places data and parity bits into a codeword
package hamming_pkg;

    localparam int DATA_W = 10;
    localparam int CODE_W = 14;
    localparam int PAR_W  = 4;

    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int P4_IDX = 3;
    localparam int P8_IDX = 7;

    // Non-power-of-two Hamming positions 3,5,6,7,9..14, minus one.
    localparam int DATA_IDX [0:DATA_W-1] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13};

    // par[0] = p1, par[1] = p2, par[2] = p4, par[3] = p8.
    function automatic logic [CODE_W-1:0] assemble_code(
        input logic [DATA_W-1:0] data,
        input logic [PAR_W-1:0]  par
    );
        logic [CODE_W-1:0] code;
        code         = '0;
        code[P1_IDX] = par[0];
        code[P2_IDX] = par[1];
        code[P4_IDX] = par[2];
        code[P8_IDX] = par[3];
        for (int j = 0; j < DATA_W; j++) begin
            code[DATA_IDX[j]] = data[j];
        end
        return code;
    endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// rtl/hamming_parity_gen.sv - combinational parity generator for the shortened Hamming(15,11) code
//
// Ports:
//   data_i [DATA_W-1:0] : data word d[9:0]
//   par_o  [PAR_W-1:0]  : even parity bits {p8, p4, p2, p1}
// Parity bit b covers every data bit whose Hamming position has bit b set.
module hamming_parity_gen
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [PAR_W-1:0]  par_o
);

    always_comb begin
        logic [3:0] pos;
        par_o = '0;
        pos   = '0;
        for (int j = 0; j < DATA_W; j++) begin
            pos = 4'(DATA_IDX[j] + 1);
            for (int b = 0; b < PAR_W; b++) begin
                if (pos[b]) begin
                    par_o[b] = par_o[b] ^ data_i[j];
                end
            end
        end
    end

endmodule

// File: rtl/pipelined_hamming_encoder.sv
// rtl/pipelined_hamming_encoder.sv - two-stage valid/ready Hamming encoder with error injection
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake, in_data + inj_mask captured on transfer
//   in_data  [9:0]       : data word
//   inj_mask [13:0]      : error pattern XORed onto the codeword
//   out_valid/out_ready  : output handshake
//   out_code [13:0]      : codeword, bit i = Hamming position i+1; 0 while out_valid = 0
//   cw_count [CNT_W-1:0] : wrapping count of delivered codewords
module pipelined_hamming_encoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [9:0]        in_data,
    input  logic [13:0]       inj_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [13:0]       out_code,
    output logic [CNT_W-1:0]  cw_count
);

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q;
    logic [CODE_W-1:0] s1_mask_q;
    logic [PAR_W-1:0]  s1_par_q;
    logic [PAR_W-1:0]  par_d;

    logic              s2_valid_q, s2_valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic in_fire;
    logic out_fire;
    logic s2_load;

    hamming_parity_gen u_parity (
        .data_i (in_data),
        .par_o  (par_d)
    );

    // Handshake: in_ready is a function of register state and out_ready only.
    assign out_fire = s2_valid_q & out_ready;
    assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_load;
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        s1_valid_d = in_fire | (s1_valid_q & ~s2_load);
        s2_valid_d = s2_load | (s2_valid_q & ~out_ready);

        // Clearing the output register when it drains keeps out_code at 0 while idle.
        code_d = code_q;
        if (s2_load) begin
            code_d = assemble_code(s1_data_q, s1_par_q) ^ s1_mask_q;
        end else if (out_fire) begin
            code_d = '0;
        end

        cnt_d = cnt_q;
        if (out_fire) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            code_q     <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
        end
    end

    // Stage-1 payload is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_data_q <= in_data;
            s1_mask_q <= inj_mask;
            s1_par_q  <= par_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_code  = code_q;
    assign cw_count  = cnt_q;

endmodule
